// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised multi-read-port register file.
// Holds the clear-sweep state encoding and the default geometry constants
// used as parameter defaults by regfile_mp and regfile_clr_fsm.
package regfile_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NREAD = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller for regfile_mp.
// Walks a pointer from entry 1 to entry DEPTH-1, one entry per cycle, and
// strobes a zero-write for each. Entered on reset or on a clear request
// sampled while idle; requests seen during a sweep are ignored.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset; restarts the sweep at 1
//   i_clr_req  in   request a full clear sweep (honoured only when idle)
//   o_busy     out  high while a sweep is in progress
//   o_clr_we   out  clear-write strobe for the entry at o_clr_addr
//   o_clr_addr out  entry being cleared this cycle
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [0:0]    S_IDLE    = IDLE;
    localparam logic [0:0]    S_CLEAR   = CLEAR;
    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [0:0]    r_state;
    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= PTR_FIRST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= PTR_FIRST;
                    end
                end
                default: begin
                    // The edge that clears the last entry also ends the sweep.
                    r_ptr <= r_ptr + PTR_FIRST;
                    if (r_ptr == PTR_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_busy     = (r_state == S_CLEAR);
    assign o_clr_we   = (r_state == S_CLEAR);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD combinational read ports and one
// write port. Entry 0 has no storage and always reads zero. A clear sweep
// (after reset or on clr_req) zeroes entries 1..DEPTH-1; during the sweep
// all read ports return zero and user writes are discarded with a
// one-cycle wr_drop pulse.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of
// wdata onto any read port addressing the entry being written.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   we       in   write enable
//   waddr    in   write address (AW bits)
//   wdata    in   write data (WIDTH bits)
//   raddr    in   read addresses, port k at [k*AW +: AW]
//   rdata    out  read data, port k at [k*WIDTH +: WIDTH]
//   clr_req  in   request a clear sweep
//   busy     out  clear sweep in progress
//   wr_drop  out  registered pulse: a write was discarded during the sweep
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NREAD = RF_NREAD,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   wr_drop
);

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wr_ok;
    logic             w_wr_bad;
    logic             r_wr_drop;
    logic [WIDTH-1:0] r_mem [1:DEPTH-1];

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Address-0 writes are neither committed nor reported as drops.
    assign w_wr_ok  = we && (waddr != '0) && !w_busy;
    assign w_wr_bad = we && (waddr != '0) && w_busy;

    // Storage carries no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_bad;
        end
    end

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_rd
            logic [AW-1:0]    w_ra;
            logic [WIDTH-1:0] w_rd;

            assign w_ra = raddr[k*AW +: AW];

            always_comb begin
                w_rd = '0;
                if (!w_busy && (w_ra != '0)) begin
                    w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
                    if (we && (waddr != '0) && (w_ra == waddr)) begin
                        w_rd = wdata;
                    end
`endif
                end
            end

            assign rdata[k*WIDTH +: WIDTH] = w_rd;
        end
    endgenerate

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the multicycle MIPS datapath and its successors. It replaces the fixed 32x32, two-read-port register file with one generalised in data width, depth and read-port count. Entry 0 is hardwired to zero. A sequential clear sweep zeroes the array after reset or on request, and an optional write-to-read bypass is available.

## Interface
Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of entries; power of two, at least 4.
- NREAD, 2, number of independent read ports, from 1 to 4.
- AW, $clog2(DEPTH), address width. Derived; never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NREAD*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NREAD*WIDTH  read data; port k is bits [k*WIDTH +: WIDTH].
- clr_req  in  1  request a full clear sweep.
- busy  out  1  high while a clear sweep is in progress.
- wr_drop  out  1  registered one-cycle pulse; a write was discarded.

## Operation
- Array holds entries 1..DEPTH-1; entry 0 has no storage.
- Reads are combinational.
  - Port k returns 0 when its address is 0.
  - Otherwise it returns the stored entry.
- Writes land at the rising edge when we=1, waddr≠0 and the FSM is in IDLE.
  - A write to address 0 is discarded silently and raises no wr_drop.
- FSM states: IDLE and CLEAR.
  - rst asserted: state goes to CLEAR and ptr goes to 1 asynchronously.
  - CLEAR, each cycle: entry[ptr] is set to 0 and ptr increments. After entry DEPTH-1 is written, the state goes to IDLE.
  - IDLE with clr_req=1: the state goes to CLEAR and ptr goes to 1 on the next edge.
  - clr_req is ignored while in CLEAR; no restart, no extension.
- busy = (state == CLEAR).
- While busy:
  - All rdata ports read 0, whatever the array contents.
  - Any write with we=1 and waddr≠0 is discarded, and wr_drop is 1 in the following cycle.
- clr_req=1 and we=1 in the same IDLE cycle: the write commits first, then the sweep clears it. wr_drop stays 0.
- rst during a sweep restarts the sweep from ptr=1.
- Entries already cleared stay cleared after rst; there is no partial-state hazard.

## Timing
- Reset values: busy=1, wr_drop=0, rdata=0 on all ports (forced while busy).
- The sweep lasts exactly DEPTH-1 cycles after rst deasserts. busy falls on the edge that writes entry DEPTH-1.
- From clr_req sampled in IDLE to busy falling again: DEPTH-1 cycles of busy.
- Write-to-read latency without bypass: the new value is visible in the cycle after the write edge.
- Read latency: 0 cycles (combinational from raddr).
- wr_drop: 1 cycle after the offending write, high for exactly 1 cycle per dropped write.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first bypass. For each port k, rdata_k = wdata combinationally when all of these hold:
  - we=1
  - not busy
  - waddr≠0
  - raddr_k == waddr
- Undefined: no bypass. The port returns the pre-write stored value until the edge, which matches the original two-port file behaviour.
- The macro has no effect on busy, wr_drop, the sweep or address-0 handling.

## Structure
- Package regfile_pkg holds:
  - The state enum (IDLE, CLEAR).
  - Default constants RF_WIDTH=32, RF_DEPTH=32, RF_NREAD=2.
- One sub-module, regfile_clr_fsm, contains the state, ptr counter, busy and clear-write strobe. It is parametrised by DEPTH.
- Read ports use a generate loop over NREAD in the top module.

## Test plan
- Reset sweep, default parameters: pulse rst, then release. Expected:
  - busy=1 for exactly 31 cycles, then 0.
  - Every raddr in 0..31 reads 0.
- Write/read: write 0xDEADBEEF to address 5, then read on both ports next cycle. Expected: 0xDEADBEEF.
  - Write 0x12345678 to address 0. Expected: address 0 still reads 0 and wr_drop=0.
- Drop during sweep: assert clr_req in IDLE, then write 0xAAAA5555 to address 3 mid-sweep. Expected:
  - wr_drop=1 for one cycle.
  - Address 3 reads 0 after busy falls.
- Simultaneous clr_req and write to address 7 (0x1): address 7 reads 0 after the sweep, and wr_drop=0.
- Reset mid-sweep: assert rst at sweep cycle 10. Expected: busy stays high for a full 31 cycles after rst releases.
- Bypass, with REGFILE_BYPASS_EN: write 0xCAFEF00D to address 9 with raddr0=9 in the same cycle. Expected:
  - rdata0=0xCAFEF00D in that same cycle.
  - Without the macro, the old value is returned in that cycle.
- Parametric: WIDTH=16, DEPTH=8, NREAD=4.
  - The sweep lasts 7 cycles.
  - Four distinct addresses read back independently.
